// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer feeding the IF/ID register from the I-cache; FETCH_CTRL_PERF_EN adds miss/flush counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int PERF_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        hazard_stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_ready_i,
  input  logic [31:0] icache_instr_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_flush_o,
`ifdef FETCH_CTRL_PERF_EN
  output logic [PERF_W-1:0] perf_miss_cycles_o,
  output logic [PERF_W-1:0] perf_flush_cnt_o,
`endif
  output logic [1:0]  state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, WAIT = 2'b10} state_t;
  state_t state, state_n;
  logic pend_valid;
  logic [31:0] pend_pc;
  logic busy, hit, take;
  logic [31:0] tgt;
  assign busy = state != IDLE;
  assign hit = busy && icache_ready_i;
  assign take = redirect_valid_i || pend_valid;
  assign tgt = redirect_valid_i ? {redirect_pc_i[31:2], 2'b00} : pend_pc;
  assign icache_req_o = busy;
  assign icache_addr_o = pc_o;
  assign state_o = state;
  // start_i only matters once no request is outstanding
  always_comb begin
    state_n = (state == IDLE || icache_ready_i) ? (start_i ? FETCH : IDLE) : WAIT;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      pc_o         <= {RESET_PC[31:2], 2'b00};
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_instr_o <= '0;
      ifid_flush_o <= 1'b0;
      pend_valid   <= 1'b0;
      pend_pc      <= '0;
    end else begin
      state        <= state_n;
      ifid_flush_o <= busy && (redirect_valid_i || (icache_ready_i && pend_valid));
      if (hit && take) begin
        pc_o         <= tgt;
        ifid_valid_o <= 1'b0;
        pend_valid   <= 1'b0;
      end else if (hit && !hazard_stall_i) begin
        ifid_pc_o    <= pc_o;
        ifid_instr_o <= icache_instr_i;
        ifid_valid_o <= 1'b1;
        pc_o         <= pc_o + 32'd4;
      end else if (!hit) begin
        if (busy && redirect_valid_i) begin
          pend_valid <= 1'b1;
          pend_pc    <= tgt;
        end
        ifid_valid_o <= ifid_valid_o && hazard_stall_i && !(busy && redirect_valid_i);
      end
    end
  end
`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_miss_cycles_o <= '0;
      perf_flush_cnt_o   <= '0;
    end else begin
      perf_miss_cycles_o <= (state == WAIT && !(&perf_miss_cycles_o)) ? perf_miss_cycles_o + 1'b1 : perf_miss_cycles_o;
      perf_flush_cnt_o   <= (ifid_flush_o && !(&perf_flush_cnt_o)) ? perf_flush_cnt_o + 1'b1 : perf_flush_cnt_o;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a queue scoreboard of instructions expected in IF/ID.
module tb_fetch_ctrl;
  logic clk = 0, rst = 1, start = 0, hazard = 0, redir = 0, ready = 1;
  logic [31:0] redir_pc = 0;
  logic req, ifid_valid, flush;
  logic [31:0] addr, instr, pc, ifid_pc, ifid_instr;
  logic [1:0] state;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_miss, perf_flush;
`endif
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  assign instr = addr ^ 32'hDEAD_BEEF;
  fetch_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hazard_stall_i(hazard),
    .redirect_valid_i(redir), .redirect_pc_i(redir_pc),
    .icache_req_o(req), .icache_addr_o(addr), .icache_ready_i(ready), .icache_instr_i(instr),
    .pc_o(pc), .ifid_valid_o(ifid_valid), .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr),
    .ifid_flush_o(flush),
`ifdef FETCH_CTRL_PERF_EN
    .perf_miss_cycles_o(perf_miss), .perf_flush_cnt_o(perf_flush),
`endif
    .state_o(state)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_ctrl(input string nm, input logic [1:0] st, input logic [31:0] p, input logic v, input logic f);
    chk({nm, ".state"}, 32'(state), 32'(st));
    chk({nm, ".pc"}, pc, p);
    chk({nm, ".addr"}, addr, p);
    chk({nm, ".valid"}, 32'(ifid_valid), 32'(v));
    chk({nm, ".flush"}, 32'(flush), 32'(f));
  endtask
  // monitor: each newly presented IF/ID instruction must match the head of the queue
  initial begin
    logic pv = 0;
    logic [31:0] ppc = 0, e;
    forever begin
      @(negedge clk);
      if (!rst && ifid_valid && (!pv || ifid_pc !== ppc)) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ifid_unexpected: got pc %h, none expected", ifid_pc);
        end else begin
          e = exp_q.pop_front();
          if (ifid_pc !== e || ifid_instr !== (e ^ 32'hDEAD_BEEF)) begin
            bad++;
            $display("FAIL ifid_data: got pc %h instr %h want pc %h instr %h", ifid_pc, ifid_instr, e, e ^ 32'hDEAD_BEEF);
          end
        end
      end
      pv = ifid_valid;
      ppc = ifid_pc;
    end
  end
  initial begin
    step(2);
    chk_ctrl("reset", 2'b00, 32'h0, 0, 0);
    chk("reset.req", 32'(req), 0);
    chk("reset.ifid_pc", ifid_pc, 0);
    chk("reset.ifid_instr", ifid_instr, 0);
    rst = 0; start = 1;
    step; chk_ctrl("t1.start", 2'b01, 32'h0, 0, 0);
    chk("t1.req", 32'(req), 1);
    exp_q.push_back(32'h0); step; chk_ctrl("t1.hit0", 2'b01, 32'h4, 1, 0);
    exp_q.push_back(32'h4); step; chk_ctrl("t1.hit4", 2'b01, 32'h8, 1, 0);
    redir = 1; redir_pc = 32'h43;
    step; chk_ctrl("t3.redir", 2'b01, 32'h40, 0, 1);
    redir = 0;
    exp_q.push_back(32'h40); step; chk_ctrl("t3.after", 2'b01, 32'h44, 1, 0);
    redir = 1; redir_pc = 32'h10;
    step; chk_ctrl("t2.setup", 2'b01, 32'h10, 0, 1);
    redir = 0; ready = 0;
    for (int i = 0; i < 3; i++) begin
      step; chk_ctrl($sformatf("t2.miss%0d", i), 2'b10, 32'h10, 0, 0);
    end
    ready = 1;
    exp_q.push_back(32'h10); step; chk_ctrl("t2.fill", 2'b01, 32'h14, 1, 0);
    ready = 0;
    step; chk_ctrl("t4.miss", 2'b10, 32'h14, 0, 0);
    redir = 1; redir_pc = 32'h80;
    step; chk_ctrl("t4.latch", 2'b10, 32'h14, 0, 1);
    redir = 0;
    step; chk_ctrl("t4.wait", 2'b10, 32'h14, 0, 0);
    ready = 1;
    step; chk_ctrl("t4.apply", 2'b01, 32'h80, 0, 1);
    exp_q.push_back(32'h80); step; chk_ctrl("t4.hit", 2'b01, 32'h84, 1, 0);
    redir = 1; redir_pc = 32'h1C;
    step; redir = 0;
    exp_q.push_back(32'h1C); step; chk_ctrl("t5.pre", 2'b01, 32'h20, 1, 0);
    hazard = 1;
    for (int i = 0; i < 2; i++) begin
      step; chk_ctrl($sformatf("t5.stall%0d", i), 2'b01, 32'h20, 1, 0);
      chk($sformatf("t5.ifid_pc%0d", i), ifid_pc, 32'h1C);
    end
    hazard = 0;
    exp_q.push_back(32'h20); step; chk_ctrl("t5.resume", 2'b01, 32'h24, 1, 0);
    redir = 1; redir_pc = 32'hFFFF_FFFC;
    step; chk_ctrl("t6.top", 2'b01, 32'hFFFF_FFFC, 0, 1);
    redir = 0;
    exp_q.push_back(32'hFFFF_FFFC); step; chk_ctrl("t6.wrap", 2'b01, 32'h0, 1, 0);
    exp_q.push_back(32'h0); step; chk_ctrl("t6.hit0", 2'b01, 32'h4, 1, 0);
    ready = 0;
    step; chk_ctrl("t6.miss", 2'b10, 32'h4, 0, 0);
    rst = 1;
    step; chk_ctrl("t6.rst", 2'b00, 32'h0, 0, 0);
    chk("t6.req", 32'(req), 0);
    rst = 0; start = 0; ready = 1;
    step; chk_ctrl("t6.idle", 2'b00, 32'h0, 0, 0);
    @(negedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
